// File: rtl/entropy_seed_ctrl.sv
// Entropy seed controller: startup self-test, continuous repetition-count
// health test, and a small sample FIFO feeding the seed CSR read value.
module entropy_seed_ctrl #(
   parameter int DEPTH        = 4,
   parameter int BIST_SAMPLES = 64,
   parameter int RCT_CUTOFF   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        EntValid,
   input  logic [15:0] EntData,
   output logic        EntReady,
   input  logic        SeedReadM,
   output logic [31:0] SeedValM,
   output logic        HealthFail
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(BIST_SAMPLES + 1);
   localparam int RW = $clog2(RCT_CUTOFF + 1);

   typedef enum logic [1:0] {
      ST_BIST = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [1:0]     opst;
   logic [15:0]    mem [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic [15:0]    prev_data;
   logic           have_prev;
   logic [RW-1:0]  rep_cnt, rep_nxt;
   logic [BW-1:0]  bist_cnt;
   logic           accept, fail, bist_done, push, pop;

   // Handshake and health-test decisions for the current cycle
   always_comb begin
      accept = EntValid & EntReady;
      if (!have_prev || (EntData != prev_data))
         rep_nxt = RW'(1);
      else if (rep_cnt == RW'(RCT_CUTOFF))
         rep_nxt = rep_cnt;
      else
         rep_nxt = rep_cnt + RW'(1);
      fail      = accept && (rep_nxt == RW'(RCT_CUTOFF));
      bist_done = accept && (state == ST_BIST) && !fail &&
                  (bist_cnt == BW'(BIST_SAMPLES - 1));
      // A failing sample is never stored, and a read racing a failure is moot
      push      = accept && (state == ST_RUN) && !fail;
      pop       = SeedReadM && (opst == 2'b10) && !fail;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_BIST;
      else       state <= state_nxt;
   end

   // Next-state logic: failure outranks BIST completion; DEAD is left only by reset
   always_comb begin
      state_nxt = state;
      case (state)
         ST_BIST: if (fail) state_nxt = ST_DEAD;
                  else if (bist_done) state_nxt = ST_RUN;
         ST_RUN:  if (fail) state_nxt = ST_DEAD;
         default: state_nxt = ST_DEAD;
      endcase
   end

   // Outputs derived from registered state only
   always_comb begin
      opst       = 2'b00;
      EntReady   = 1'b0;
      HealthFail = 1'b0;
      case (state)
         ST_BIST: begin
            opst     = 2'b00;
            EntReady = 1'b1;
         end
         ST_RUN: begin
            opst     = (count == '0) ? 2'b01 : 2'b10;
            EntReady = (count != CW'(DEPTH));
         end
         default: begin
            opst       = 2'b11;
            HealthFail = 1'b1;
         end
      endcase
      SeedValM = {opst, 14'b0, (opst == 2'b10) ? mem[rd_ptr] : 16'h0};
   end

   // Repetition-count tracker, updated on every accepted sample
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         have_prev <= 1'b0;
         prev_data <= '0;
         rep_cnt   <= '0;
      end else if (accept) begin
         have_prev <= 1'b1;
         prev_data <= EntData;
         rep_cnt   <= rep_nxt;
      end
   end

   // Self-test sample counter, saturating at the required sample count
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bist_cnt <= '0;
      else if (accept && (state == ST_BIST) && (bist_cnt != BW'(BIST_SAMPLES)))
         bist_cnt <= bist_cnt + BW'(1);
   end

   // FIFO pointers and occupancy; flushed on failure and held empty in DEAD
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (fail || (state == ST_DEAD)) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; stale contents are masked by OPST so no reset is needed
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= EntData;
   end

endmodule
